alu_seq: RTL and testbench

Registered, handshaked N-bit ALU with status flags, an accumulator and a multi-cycle multiply. It replaces the purely combinational ALU in datapaths that need pipelined timing, flow control and chained operations. It sits between an operand source (valid/ready producer) and a result consumer (valid/ready sink). It processes one operation at a time.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_mul_seq.sv | 53 +++++
 rtl/alu_seq.sv | 152 +++++++++++++++
 tb/tb_alu_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, status flags and FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } flags_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier, one multiplier bit per cycle. The first bit is consumed on
// the start cycle itself, so done (the Nth bit) fires N-1 cycles after start.
module alu_mul_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N) + 1;

  logic [2*N-1:0] mcand_q, prod_q, prod_d, mc, pa;
  logic [N-1:0]   mplier_q, mp;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;

  // On start the fresh operands bypass the registers so the first iteration is not lost.
  assign mc      = start ? {{N{1'b0}}, a} : mcand_q;
  assign mp      = start ? b : mplier_q;
  assign pa      = start ? '0 : prod_q;
  assign prod_d  = pa + (mp[0] ? mc : '0);
  assign done    = busy_q && (cnt_q == CW'(N - 1));
  assign product = prod_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start || busy_q) begin
      prod_q   <= prod_d;
      mcand_q  <= mc << 1;
      mplier_q <= mp >> 1;
      if (start) begin
        cnt_q  <= CW'(1);
        busy_q <= 1'b1;
      end else if (done) begin
        cnt_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered, handshaked ALU with flags and accumulator; single-cycle ops resolve at
// accept, MUL is delegated to the sequential multiplier.
module alu_seq
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   opcode,
  input  logic         acc_sel,
  input  logic         acc_clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Y,
  output logic [3:0]   flags
);

  localparam int SW = $clog2(N);

  typedef struct packed {
    logic [N-1:0] y;
    flags_t       f;
  } res_t;

  function automatic res_t alu_f(input op_e op, input logic [N-1:0] a, input logic [N-1:0] b);
    res_t          r;
    logic [N:0]    w;
    logic [SW-1:0] sh;
    r  = '0;
    w  = '0;
    sh = b[SW-1:0];
    case (op)
      OP_ADD: begin
        w     = {1'b0, a} + {1'b0, b};
        r.y   = w[N-1:0];
        r.f.c = w[N];
        r.f.v = (a[N-1] == b[N-1]) && (r.y[N-1] != a[N-1]);
      end
      OP_SUB: begin
        w     = {1'b0, a} - {1'b0, b};
        r.y   = w[N-1:0];
        r.f.c = w[N];
        r.f.v = (a[N-1] != b[N-1]) && (r.y[N-1] != a[N-1]);
      end
      OP_AND: r.y = a & b;
      OP_OR:  r.y = a | b;
      OP_XOR: r.y = a ^ b;
      // The extra guard bit catches the last bit shifted out; it stays 0 for sh==0.
      OP_SHL: begin
        w     = {1'b0, a} << sh;
        r.y   = w[N-1:0];
        r.f.c = w[N];
      end
      OP_SHR: begin
        w     = {a, 1'b0} >> sh;
        r.y   = w[N:1];
        r.f.c = w[0];
      end
      default: r = '0;
    endcase
    r.f.n = r.y[N-1];
    r.f.z = (r.y == '0);
    return r;
  endfunction

  state_e         state_q, state_d;
  logic [N-1:0]   y_q, y_d, acc_q, acc_d, op_a;
  flags_t         flags_q, flags_d;
  logic           out_valid_q, load, mul_start, mul_done;
  logic [2*N-1:0] mul_prod;
  res_t           alu_res;

  assign op_a      = acc_sel ? acc_q : A;
  assign alu_res   = alu_f(op_e'(opcode), op_a, B);
  assign mul_start = (state_q == IDLE) && in_valid && (op_e'(opcode) == OP_MUL);

  alu_mul_seq #(.N(N)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (op_a),
    .b       (B),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    flags_d = flags_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (op_e'(opcode) == OP_MUL) begin
            state_d = BUSY;
          end else begin
            state_d = DONE;
            y_d     = alu_res.y;
            flags_d = alu_res.f;
            load    = 1'b1;
          end
        end
      end
      BUSY: begin
        if (mul_done) begin
          state_d   = DONE;
          y_d       = mul_prod[N-1:0];
          flags_d.v = 1'b0;
          flags_d.c = |mul_prod[2*N-1:N];
          flags_d.n = mul_prod[N-1];
          flags_d.z = (mul_prod[N-1:0] == '0);
          load      = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A clear in the same cycle as a result load takes priority.
  assign acc_d = acc_clr ? '0 : (load ? y_d : acc_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      y_q         <= '0;
      flags_q     <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      flags_q     <= flags_d;
      acc_q       <= acc_d;
      out_valid_q <= (state_d == DONE);
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign Y         = y_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (N=8) with hand-computed results, flags and latencies.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic [2:0]   opcode = '0;
  logic         acc_sel = 1'b0;
  logic         acc_clr = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] Y;
  logic [3:0]   flags;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_seq #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .opcode    (opcode),
    .acc_sel   (acc_sel),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .flags     (flags)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an operation and return just after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic sel, input logic clr);
    int guard;
    guard = 0;
    opcode = op; A = a; B = b; acc_sel = sel; acc_clr = clr; in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0; acc_sel = 1'b0; acc_clr = 1'b0;
  endtask

  // Latency counts edges from accept until out_valid is seen high (1 = next edge).
  task automatic collect(input string tag, input logic [N-1:0] exp_y, input logic [3:0] exp_f,
                         input int exp_lat);
    int lat;
    lat = 1;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    $display("op %s: Y=0x%0h flags=%b latency=%0d", tag, Y, flags, lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_y"}, {24'd0, Y}, {24'd0, exp_y});
    chk({tag, "_flags"}, {28'd0, flags}, {28'd0, exp_f});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    // Reset state
    step(); step(); step();
    chk("rst_y", {24'd0, Y}, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_ir", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    step();

    // Single-cycle ops; flags are {V,C,N,Z}
    issue(OP_ADD, 8'd73, 8'd42, 1'b0, 1'b0);   collect("add", 8'd115, 4'b0000, 1);
    issue(OP_SUB, 8'd42, 8'd73, 1'b0, 1'b0);   collect("sub", 8'd225, 4'b0110, 1);
    issue(OP_ADD, 8'd100, 8'd100, 1'b0, 1'b0); collect("add_ovf", 8'd200, 4'b1010, 1);
    issue(OP_XOR, 8'h5A, 8'h5A, 1'b0, 1'b0);   collect("xor_zero", 8'h00, 4'b0001, 1);
    issue(OP_SUB, 8'h80, 8'h01, 1'b0, 1'b0);   collect("sub_ovf", 8'h7F, 4'b1000, 1);
    issue(OP_AND, 8'hF0, 8'h3C, 1'b0, 1'b0);   collect("and", 8'h30, 4'b0000, 1);
    issue(OP_OR, 8'h80, 8'h01, 1'b0, 1'b0);    collect("or", 8'h81, 4'b0010, 1);
    issue(OP_SHL, 8'h81, 8'h01, 1'b0, 1'b0);   collect("shl1", 8'h02, 4'b0100, 1);
    issue(OP_SHR, 8'h81, 8'h01, 1'b0, 1'b0);   collect("shr1", 8'h40, 4'b0100, 1);
    issue(OP_SHL, 8'h80, 8'h08, 1'b0, 1'b0);   collect("shl0", 8'h80, 4'b0010, 1);
    issue(OP_SHR, 8'h03, 8'h02, 1'b0, 1'b0);   collect("shr2", 8'h00, 4'b0101, 1);

    // MUL: busy for 7 edges, valid seen at the 8th
    issue(OP_MUL, 8'd73, 8'd42, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) begin
      chk("mul_busy_ir", {31'd0, in_ready}, 32'd0);
      chk("mul_busy_ov", {31'd0, out_valid}, 32'd0);
      step();
    end
    collect("mul", 8'hFA, 4'b0110, 1);
    issue(OP_MUL, 8'd3, 8'd5, 1'b0, 1'b0);     collect("mul_small", 8'd15, 4'b0000, 8);
    issue(OP_MUL, 8'd16, 8'd16, 1'b0, 1'b0);   collect("mul_wrap", 8'd0, 4'b0101, 8);

    // Backpressure with ignored input pulses
    issue(OP_ADD, 8'd1, 8'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      opcode = OP_SUB; A = 8'd9; B = 8'd9; in_valid = 1'b1;
      chk("bp_y", {24'd0, Y}, 32'd3);
      chk("bp_flags", {28'd0, flags}, 32'd0);
      chk("bp_ov", {31'd0, out_valid}, 32'd1);
      chk("bp_ir", {31'd0, in_ready}, 32'd0);
      step();
    end
    in_valid = 1'b0;
    collect("bp", 8'd3, 4'b0000, 1);
    step(); step();
    chk("bp_no_extra", {31'd0, out_valid}, 32'd0);

    // Accumulator chaining and clear priority
    issue(OP_ADD, 8'd10, 8'd5, 1'b0, 1'b0);    collect("acc_load", 8'd15, 4'b0000, 1);
    issue(OP_ADD, 8'hEE, 8'd1, 1'b1, 1'b0);    collect("acc_use", 8'd16, 4'b0000, 1);
    issue(OP_ADD, 8'd3, 8'd4, 1'b0, 1'b1);     collect("acc_clr_load", 8'd7, 4'b0000, 1);
    issue(OP_ADD, 8'hEE, 8'd0, 1'b1, 1'b0);    collect("acc_after_clr", 8'd0, 4'b0001, 1);
    issue(OP_ADD, 8'd10, 8'd5, 1'b0, 1'b0);    collect("acc_reload", 8'd15, 4'b0000, 1);
    acc_clr = 1'b1; step(); acc_clr = 1'b0;
    issue(OP_ADD, 8'hEE, 8'd2, 1'b1, 1'b0);    collect("acc_idle_clr", 8'd2, 4'b0000, 1);

    // Reset in the middle of a multiply
    issue(OP_ADD, 8'd20, 8'd22, 1'b0, 1'b0);   collect("pre_rst", 8'd42, 4'b0000, 1);
    issue(OP_MUL, 8'd7, 8'd9, 1'b0, 1'b0);
    step(); step(); step();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_ir", {31'd0, in_ready}, 32'd1);
    chk("rst_mid_y", {24'd0, Y}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("rst_no_result", {31'd0, out_valid}, 32'd0);
      step();
    end
    issue(OP_ADD, 8'hEE, 8'd0, 1'b1, 1'b0);    collect("rst_acc_zero", 8'd0, 4'b0001, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
